// File: rtl/execute_pkg.sv
// Shared definitions for the multi-cycle multiply/divide execute unit:
// uop encodings, FSM states and fault codes.
package execute_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic FAULT_NONE = 1'b0;
  localparam logic FAULT_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step_ex.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on a 2*WIDTH accumulator holding {high/remainder, low/quotient}.
module muldiv_step_ex #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, operand});
    diff     = rem_sh[WIDTH-1:0] - operand;
    q_bit    = 1'b0;
    acc_next = '0;
    if (is_div) begin
      // LSB is left clear; the caller drops q_bit into the freed quotient slot
      q_bit    = ge;
      acc_next = {(ge ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_ex.sv
// Multi-cycle MUL/IMUL/DIV/IDIV execute unit: accepts a uop when idle, iterates
// WIDTH cycles, then holds the result for WB until it is taken.
module execute_muldiv_ex
  import execute_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DR_W  = 3,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EX_V,
  input  logic [1:0]       EX_OP,
  input  logic [WIDTH-1:0] EX_A,
  input  logic [WIDTH-1:0] EX_B,
  input  logic [DR_W-1:0]  EX_DR1,
  input  logic [DR_W-1:0]  EX_DR2,
  input  logic             WB_stall,
  output logic             EX_ready,
  output logic             WB_V_next,
  output logic [WIDTH-1:0] WB_RESULT_A_next,
  output logic [WIDTH-1:0] WB_RESULT_B_next,
  output logic [DR_W-1:0]  WB_DR1_next,
  output logic [DR_W-1:0]  WB_DR2_next,
  output logic             WB_fault_next,
  output logic             WB_ld_latches
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg, neg_res_reg, neg_rem_reg, ovf_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opd_reg;

  logic             in_div, in_signed, sign_a, sign_b, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    in_div    = (EX_OP == OP_DIVU) || (EX_OP == OP_DIVS);
    in_signed = (EX_OP == OP_MULS) || (EX_OP == OP_DIVS);
    sign_a    = in_signed & EX_A[WIDTH-1];
    sign_b    = in_signed & EX_B[WIDTH-1];
    mag_a     = sign_a ? -EX_A : EX_A;
    mag_b     = sign_b ? -EX_B : EX_B;
    div_zero  = in_div && (EX_B == '0);
    div_ovf   = (EX_OP == OP_DIVS) && (EX_A == MOST_NEG) && (EX_B == '1);
  end

  logic [2*WIDTH-1:0] step_acc, acc_fin, prod_fix;
  logic               step_q;
  logic [WIDTH-1:0]   quo, rem, fin_a, fin_b;

  muldiv_step_ex #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .operand  (opd_reg),
    .is_div   (is_div_reg),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Sign fix applied to the final iteration's result on the RUN->DONE edge
  always_comb begin
    acc_fin  = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
    prod_fix = neg_res_reg ? -acc_fin : acc_fin;
    quo      = acc_fin[WIDTH-1:0];
    rem      = acc_fin[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      fin_a = neg_res_reg ? -quo : quo;
      fin_b = neg_rem_reg ? -rem : rem;
    end else begin
      fin_a = prod_fix[WIDTH-1:0];
      fin_b = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      is_div_reg       <= 1'b0;
      neg_res_reg      <= 1'b0;
      neg_rem_reg      <= 1'b0;
      ovf_reg          <= 1'b0;
      acc_reg          <= '0;
      opd_reg          <= '0;
      WB_RESULT_A_next <= '0;
      WB_RESULT_B_next <= '0;
      WB_DR1_next      <= '0;
      WB_DR2_next      <= '0;
      WB_fault_next    <= FAULT_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (EX_V) begin
            is_div_reg  <= in_div;
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= sign_a;
            ovf_reg     <= div_ovf;
            acc_reg     <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            opd_reg     <= in_div ? mag_b : mag_a;
            cnt_reg     <= CNT_W'(WIDTH);
            WB_DR1_next <= EX_DR1;
            WB_DR2_next <= EX_DR2;
            if (div_zero) begin
              WB_RESULT_A_next <= '0;
              WB_RESULT_B_next <= '0;
              WB_fault_next    <= FAULT_DIV;
              state_reg        <= ST_DONE;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_reg <= acc_fin;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            WB_RESULT_A_next <= ovf_reg ? MOST_NEG : fin_a;
            WB_RESULT_B_next <= ovf_reg ? '0 : fin_b;
            WB_fault_next    <= ovf_reg ? FAULT_DIV : FAULT_NONE;
            state_reg        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!WB_stall) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign EX_ready      = (state_reg == ST_IDLE);
  assign WB_V_next     = (state_reg == ST_DONE);
  assign WB_ld_latches = (state_reg == ST_DONE) && !WB_stall;

endmodule

// File: tb/tb_execute_muldiv_ex.sv
// Bench for execute_muldiv_ex: directed corner cases plus random uops checked
// against an arithmetic reference model.
module tb_execute_muldiv_ex;
  import execute_pkg::*;

  localparam int W    = 32;
  localparam int DR_W = 3;

  logic            CLK = 1'b0;
  logic            CLR = 1'b0;
  logic            EX_V = 1'b0;
  logic [1:0]      EX_OP = '0;
  logic [W-1:0]    EX_A = '0, EX_B = '0;
  logic [DR_W-1:0] EX_DR1 = '0, EX_DR2 = '0;
  logic            WB_stall = 1'b0;
  logic            EX_ready, WB_V_next, WB_fault_next, WB_ld_latches;
  logic [W-1:0]    WB_RESULT_A_next, WB_RESULT_B_next;
  logic [DR_W-1:0] WB_DR1_next, WB_DR2_next;

  int checks = 0;
  int errors = 0;

  execute_muldiv_ex #(.WIDTH(W), .DR_W(DR_W)) dut (
    .CLK              (CLK),
    .CLR              (CLR),
    .EX_V             (EX_V),
    .EX_OP            (EX_OP),
    .EX_A             (EX_A),
    .EX_B             (EX_B),
    .EX_DR1           (EX_DR1),
    .EX_DR2           (EX_DR2),
    .WB_stall         (WB_stall),
    .EX_ready         (EX_ready),
    .WB_V_next        (WB_V_next),
    .WB_RESULT_A_next (WB_RESULT_A_next),
    .WB_RESULT_B_next (WB_RESULT_B_next),
    .WB_DR1_next      (WB_DR1_next),
    .WB_DR2_next      (WB_DR2_next),
    .WB_fault_next    (WB_fault_next),
    .WB_ld_latches    (WB_ld_latches)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign/zero-extended 64-bit values
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] ra, output logic [W-1:0] rb, output logic f);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    logic [W-1:0] mn;
    mn = {1'b1, {(W-1){1'b0}}};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    f  = 1'b0;
    ra = '0;
    rb = '0;
    case (op)
      OP_MULU: begin p = ua * ub; ra = p[W-1:0]; rb = p[2*W-1:W]; end
      OP_MULS: begin p = sa * sb; ra = p[W-1:0]; rb = p[2*W-1:W]; end
      OP_DIVU: begin
        if (b == '0) f = 1'b1;
        else begin ra = W'(ua / ub); rb = W'(ua % ub); end
      end
      default: begin
        if (b == '0) f = 1'b1;
        else if (a == mn && sb == -1) begin f = 1'b1; ra = mn; rb = '0; end
        else begin q = sa / sb; r = sa % sb; ra = W'(q); rb = W'(r); end
      end
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall, input bit poke);
    logic [W-1:0]    ea, eb;
    logic            ef;
    logic [DR_W-1:0] d1, d2;
    int              t, lat, exp_lat;
    model(op, a, b, ea, eb, ef);
    d1 = DR_W'($urandom);
    d2 = DR_W'($urandom);
    @(negedge CLK);
    t = 0;
    while (!EX_ready && t < 100) begin @(negedge CLK); t++; end
    check({name, "_ready"}, 64'(EX_ready), 64'(1));
    EX_V = 1'b1; EX_OP = op; EX_A = a; EX_B = b; EX_DR1 = d1; EX_DR2 = d2;
    @(negedge CLK);
    EX_V = 1'b0; EX_A = W'($urandom); EX_B = W'($urandom);
    EX_DR1 = DR_W'($urandom); EX_DR2 = DR_W'($urandom);
    lat = 1;
    while (!WB_V_next && lat < 200) begin @(negedge CLK); lat++; end
    exp_lat = (op[1] && b == '0) ? 1 : W + 1;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i <= stall; i++) begin
      WB_stall = (i < stall);
      EX_V     = poke && (i < stall);
      #1;
      check({name, "_a"}, 64'(WB_RESULT_A_next), 64'(ea));
      check({name, "_b"}, 64'(WB_RESULT_B_next), 64'(eb));
      check({name, "_fault"}, 64'(WB_fault_next), 64'(ef));
      check({name, "_dr1"}, 64'(WB_DR1_next), 64'(d1));
      check({name, "_dr2"}, 64'(WB_DR2_next), 64'(d2));
      check({name, "_valid"}, {62'd0, WB_V_next, EX_ready}, 64'(2));
      check({name, "_ld"}, 64'(WB_ld_latches), 64'(i == stall));
      @(negedge CLK);
    end
    WB_stall = 1'b0;
    EX_V     = 1'b0;
    check({name, "_after"}, {61'd0, EX_ready, WB_V_next, WB_ld_latches}, 64'(4));
    $display("op %s: op=%0d a=%h b=%h -> A=%h B=%h fault=%0d lat=%0d stall=%0d",
             name, op, a, b, WB_RESULT_A_next, WB_RESULT_B_next, WB_fault_next, lat, stall);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mn;
    logic [1:0]   rop;
    mn = {1'b1, {(W-1){1'b0}}};

    repeat (3) @(negedge CLK);
    check("reset_ready", 64'(EX_ready), 64'(1));
    check("reset_outs", {WB_RESULT_A_next, WB_RESULT_B_next}, 64'(0));
    check("reset_flags", {56'd0, WB_V_next, WB_fault_next, WB_ld_latches, WB_DR1_next, WB_DR2_next[0]}, 64'(0));
    CLR = 1'b1;

    run_op("mulu_max", OP_MULU, '1, '1, 0, 1'b0);
    check("mulu_max_const", {WB_RESULT_B_next, WB_RESULT_A_next}, 64'hFFFFFFFE_00000001);
    run_op("divs_m7_2", OP_DIVS, W'(-7), W'(2), 0, 1'b0);
    check("divs_m7_2_const", {WB_RESULT_A_next, WB_RESULT_B_next}, 64'hFFFFFFFD_FFFFFFFF);
    run_op("divu_zero", OP_DIVU, W'(123), '0, 0, 1'b0);
    run_op("divs_zero", OP_DIVS, W'(-5), '0, 0, 1'b0);
    run_op("divs_ovf", OP_DIVS, mn, '1, 0, 1'b0);
    run_op("muls_min", OP_MULS, mn, '1, 0, 1'b0);
    run_op("stall5", OP_MULS, W'(-1234), W'(5678), 5, 1'b1);

    // Asynchronous reset in the middle of RUN discards the op and clears outputs
    @(negedge CLK);
    EX_V = 1'b1; EX_OP = OP_MULU; EX_A = W'(77); EX_B = W'(99);
    @(negedge CLK);
    EX_V = 1'b0;
    repeat (9) @(negedge CLK);
    CLR = 1'b0;
    #1;
    check("midrun_ready", {62'd0, EX_ready, WB_V_next}, 64'(2));
    check("midrun_outs", {WB_RESULT_A_next, WB_RESULT_B_next}, 64'(0));
    check("midrun_flags", {58'd0, WB_fault_next, WB_ld_latches, WB_DR1_next, WB_DR2_next[0]}, 64'(0));
    $display("op reset_midrun: ready=%0d valid=%0d", EX_ready, WB_V_next);
    @(negedge CLK);
    CLR = 1'b1;
    run_op("muls_m3_5", OP_MULS, W'(-3), W'(5), 0, 1'b0);
    check("muls_m3_5_const", {WB_RESULT_A_next, WB_RESULT_B_next}, 64'hFFFFFFF1_FFFFFFFF);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = mn;
        3: rb = W'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
